// File: rtl/core_pkg.sv
// Shared types for the 8-bit core: ALU op codes, instruction opcodes,
// control-sequencer states and instruction field positions.
`default_nettype none

package core_pkg;

  localparam int INSTR_W = 9;
  localparam int OPC_MSB = 8;
  localparam int OPC_LSB = 5;
  localparam int RA_MSB  = 4;
  localparam int RA_LSB  = 3;
  localparam int RB_MSB  = 2;
  localparam int RB_LSB  = 1;
  localparam int IMM_MSB = 2;
  localparam int IMM_LSB = 0;
  localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

  typedef enum logic [3:0] {
    ALU_AND = 4'd0,
    ALU_SLT = 4'd1,
    ALU_OR  = 4'd2,
    ALU_NOT = 4'd3,
    ALU_ADD = 4'd4,
    ALU_SUB = 4'd5,
    ALU_LW  = 4'd6,
    ALU_BEQ = 4'd7,
    ALU_SRL = 4'd8,
    ALU_SRA = 4'd9,
    ALU_SLL = 4'd10
  } alu_op_e;

  typedef enum logic [3:0] {
    OP_AND      = 4'd0,
    OP_SLT      = 4'd1,
    OP_OR       = 4'd2,
    OP_NOT      = 4'd3,
    OP_ADD      = 4'd4,
    OP_SUB      = 4'd5,
    OP_LW       = 4'd6,
    OP_BEQ      = 4'd7,
    OP_SRL      = 4'd8,
    OP_SRA      = 4'd9,
    OP_SLL      = 4'd10,
    OP_SW       = 4'd11,
    OP_LI       = 4'd12,
    OP_NOP      = 4'd13,
    OP_HALT     = 4'd14,
    OP_HALT_ALT = 4'd15
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } ctrl_state_e;

endpackage

`default_nettype wire

// File: rtl/instr_decode.sv
// Combinational opcode decoder: ALU command plus the control flags that
// steer the sequencer in core_ctrl.
`default_nettype none

module instr_decode
  import core_pkg::*;
(
  input  logic [OPC_W-1:0] opcode_i,
  output alu_op_e          alu_op_o,
  output logic             writes_rf_o,
  output logic             is_mem_o,
  output logic             is_store_o,
  output logic             is_branch_o,
  output logic             is_halt_o,
  output logic             use_imm_o
);

  always_comb begin
    alu_op_o    = ALU_AND;
    writes_rf_o = 1'b0;
    is_mem_o    = 1'b0;
    is_store_o  = 1'b0;
    is_branch_o = 1'b0;
    is_halt_o   = 1'b0;
    use_imm_o   = 1'b0;
    case (opcode_i)
      OP_AND, OP_SLT, OP_OR, OP_NOT, OP_ADD, OP_SUB,
      OP_SRL, OP_SRA, OP_SLL: begin
        alu_op_o    = alu_op_e'(opcode_i);
        writes_rf_o = 1'b1;
      end
      OP_LW: begin
        alu_op_o    = ALU_LW;
        writes_rf_o = 1'b1;
        is_mem_o    = 1'b1;
      end
      OP_BEQ: begin
        alu_op_o    = ALU_BEQ;
        is_branch_o = 1'b1;
      end
      // Stores form their address exactly like loads.
      OP_SW: begin
        alu_op_o   = ALU_LW;
        is_mem_o   = 1'b1;
        is_store_o = 1'b1;
      end
      OP_LI: begin
        writes_rf_o = 1'b1;
        use_imm_o   = 1'b1;
      end
      OP_NOP: begin
      end
      default: is_halt_o = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/core_ctrl.sv
// Multi-cycle control sequencer: fetch, decode, execute on the external ALU,
// data-memory access and register write-back for the 9-bit instruction set.
`default_nettype none

module core_ctrl
  import core_pkg::*;
#(
  parameter int REG_WIDTH = 8,
  parameter int OP_WIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  output logic                 imem_req_o,
  output logic [REG_WIDTH-1:0] imem_addr_o,
  input  logic                 imem_valid_i,
  input  logic [INSTR_W-1:0]   imem_data_i,
  output logic [1:0]           rf_ra_sel_o,
  output logic [1:0]           rf_rb_sel_o,
  input  logic [REG_WIDTH-1:0] rf_ra_data_i,
  input  logic [REG_WIDTH-1:0] rf_rb_data_i,
  output logic                 rf_we_o,
  output logic [1:0]           rf_wsel_o,
  output logic [REG_WIDTH-1:0] rf_wdata_o,
  output logic [OP_WIDTH-1:0]  alu_op_o,
  output logic [REG_WIDTH-1:0] alu_a_o,
  output logic [REG_WIDTH-1:0] alu_b_o,
  input  logic [REG_WIDTH-1:0] alu_res_i,
  input  logic                 alu_jump_i,
  output logic                 dmem_req_o,
  output logic                 dmem_we_o,
  output logic [REG_WIDTH-1:0] dmem_addr_o,
  output logic [REG_WIDTH-1:0] dmem_wdata_o,
  input  logic                 dmem_valid_i,
  input  logic [REG_WIDTH-1:0] dmem_rdata_i,
  output logic [REG_WIDTH-1:0] pc_o,
  output logic                 halted_o
);

  ctrl_state_e          state_q, state_d;
  logic [REG_WIDTH-1:0] pc_q, pc_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic [REG_WIDTH-1:0] opa_q, opa_d;
  logic [REG_WIDTH-1:0] opb_q, opb_d;
  logic [REG_WIDTH-1:0] res_q, res_d;

  alu_op_e    dec_alu_op;
  logic       dec_writes_rf;
  logic       dec_is_mem;
  logic       dec_is_store;
  logic       dec_is_branch;
  logic       dec_is_halt;
  logic       dec_use_imm;
  logic       alu_used;
  logic [1:0] fld_ra;
  logic [1:0] fld_rb;
  logic [REG_WIDTH-1:0] pc_inc;

  instr_decode u_decode (
    .opcode_i    (ir_q[OPC_MSB:OPC_LSB]),
    .alu_op_o    (dec_alu_op),
    .writes_rf_o (dec_writes_rf),
    .is_mem_o    (dec_is_mem),
    .is_store_o  (dec_is_store),
    .is_branch_o (dec_is_branch),
    .is_halt_o   (dec_is_halt),
    .use_imm_o   (dec_use_imm)
  );

  assign fld_ra   = ir_q[RA_MSB:RA_LSB];
  assign fld_rb   = ir_q[RB_MSB:RB_LSB];
  assign pc_inc   = pc_q + REG_WIDTH'(1);
  assign alu_used = (dec_writes_rf & ~dec_use_imm) | dec_is_mem | dec_is_branch;
  assign pc_o     = pc_q;
  assign halted_o = (state_q == ST_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    res_d        = res_q;
    imem_req_o   = 1'b0;
    imem_addr_o  = '0;
    rf_ra_sel_o  = 2'd0;
    rf_rb_sel_o  = 2'd0;
    rf_we_o      = 1'b0;
    rf_wsel_o    = 2'd0;
    rf_wdata_o   = '0;
    alu_op_o     = '0;
    alu_a_o      = '0;
    alu_b_o      = '0;
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_addr_o  = '0;
    dmem_wdata_o = '0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          pc_d    = '0;
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        imem_req_o  = 1'b1;
        imem_addr_o = pc_q;
        if (imem_valid_i) begin
          ir_d    = imem_data_i;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        // Memory ops take the address from rb and store data from ra,
        // so the read ports swap roles to keep the address on alu_a.
        if (dec_is_mem) begin
          rf_ra_sel_o = fld_rb;
          rf_rb_sel_o = fld_ra;
        end else begin
          rf_ra_sel_o = fld_ra;
          rf_rb_sel_o = fld_rb;
        end
        opa_d   = rf_ra_data_i;
        opb_d   = rf_rb_data_i;
        state_d = dec_is_halt ? ST_HALT : ST_EXEC;
      end

      ST_EXEC: begin
        if (alu_used) begin
          alu_op_o = OP_WIDTH'(dec_alu_op);
          alu_a_o  = opa_q;
          alu_b_o  = opb_q;
        end
        // The read port is idle here, so it fetches the branch target R3.
        if (dec_is_branch) begin
          rf_ra_sel_o = 2'd3;
        end
        res_d = dec_use_imm ? REG_WIDTH'(ir_q[IMM_MSB:IMM_LSB]) : alu_res_i;
        if (dec_is_mem) begin
          state_d = ST_MEM;
        end else if (dec_writes_rf) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_FETCH;
          pc_d    = (dec_is_branch && alu_jump_i) ? rf_ra_data_i : pc_inc;
        end
      end

      ST_MEM: begin
        dmem_req_o   = 1'b1;
        dmem_addr_o  = res_q;
        dmem_we_o    = dec_is_store;
        dmem_wdata_o = dec_is_store ? opb_q : '0;
        if (dmem_valid_i) begin
          if (dec_is_store) begin
            pc_d    = pc_inc;
            state_d = ST_FETCH;
          end else begin
            res_d   = dmem_rdata_i;
            state_d = ST_WB;
          end
        end
      end

      ST_WB: begin
        rf_we_o    = 1'b1;
        rf_wsel_o  = fld_ra;
        rf_wdata_o = res_q;
        pc_d       = pc_inc;
        state_d    = ST_FETCH;
      end

      ST_HALT: begin
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: doc/core_ctrl.md
# core_ctrl

Multi-cycle control sequencer that drives the 8-bit ALU. It fetches 9-bit instructions, decodes them, and reads a 4-entry register file. It issues ALU op codes and operands, sequences data-memory loads and stores, and writes results back. It sits between instruction/data memories, the register file and the ALU, and generates every ALU `op` value.

## Interface
- `REG_WIDTH`, 8, datapath and PC width
- `OP_WIDTH`, 4, ALU op code width
- `clk` in 1: single clock
- `rst_n` in 1: asynchronous active-low reset
- `start` in 1: begin execution at PC 0 (sampled in IDLE)
- `imem_req` out 1, `imem_addr` out 8: instruction fetch request and address
- `imem_valid` in 1, `imem_data` in 9: fetch completion and instruction word
- `rf_ra_sel` out 2, `rf_rb_sel` out 2: register read selects
- `rf_ra_data` in 8, `rf_rb_data` in 8: combinational read data
- `rf_we` out 1, `rf_wsel` out 2, `rf_wdata` out 8: register write port
- `alu_op` out 4, `alu_a` out 8, `alu_b` out 8: ALU command and operands
- `alu_res` in 8, `alu_jump` in 1: ALU result and BEQ compare outcome
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out 8, `dmem_wdata` out 8: data memory request
- `dmem_valid` in 1, `dmem_rdata` in 8: data memory completion and read data
- `pc` out 8: current PC
- `halted` out 1: HALT executed

## Operation
- Instruction fields: `[8:5]` opcode, `[4:3]` rd/ra, `[2:1]` rb, `[2:0]` imm3 (LI only).
- Opcodes 0–5 and 8–10 (AND, SLT, OR, NOT, ADD, SUB, SRL, SRA, SLL):
  - issue `alu_op` = opcode, `alu_a` = R[ra], `alu_b` = R[rb];
  - then R[rd] ← `alu_res`.
- Opcode 6, LW: `alu_op`=6, `alu_a`=R[rb], then `dmem_addr`=`alu_res`, read; R[rd] ← `dmem_rdata`.
- Opcode 7, BEQ: `alu_op`=7 on R[ra], R[rb].
  - `alu_jump`=1 → PC ← R[3].
  - Otherwise PC ← PC+1.
- Opcode 11, SW: address path as LW; `dmem_wdata`=R[ra], `dmem_we`=1.
- Opcode 12, LI: R[rd] ← zero-extended imm3; no ALU access.
- Opcode 13, NOP: no action.
- Opcodes 14–15, HALT: enter HALT.
- PC arithmetic is mod 256; PC 255+1 wraps to 0.

## Timing
- Reset (async, any state) forces:
  - state IDLE;
  - `pc`, instruction register, `halted`, and all request, enable and data outputs to 0.
- An in-flight memory request is abandoned on reset.
- States: IDLE → FETCH → DECODE → EXEC → {MEM, WB, FETCH} ; MEM → {WB, FETCH} ; WB → FETCH ; HALT.
- IDLE: `start`=1 → FETCH with PC=0. `start` has no effect outside IDLE.
- FETCH:
  - `imem_req`=1 and `imem_addr`=PC held until the cycle `imem_valid`=1;
  - the instruction is captured on that edge, then DECODE.
- DECODE, one cycle: selects driven; operands registered at end of cycle.
- EXEC, one cycle:
  - `alu_op`/`alu_a`/`alu_b` driven from the registered operands;
  - `alu_res` and `alu_jump` captured at the edge.
  - Exits: BEQ/NOP → FETCH with the PC update; LW/SW → MEM; others → WB.
- MEM:
  - `dmem_req`=1 held until `dmem_valid`=1;
  - LW → WB; SW → FETCH with PC+1.
  - `dmem_we` is valid only while `dmem_req`=1.
- WB, one cycle: `rf_we`=1, PC ← PC+1, then FETCH.
- HALT is decoded in DECODE:
  - `halted`=1 from the next cycle;
  - PC frozen at the HALT address;
  - no requests issued until reset.
- `alu_op` is 0 outside EXEC; `rf_we` is 0 outside WB.
- Zero-wait latency:
  - ALU op and LI: 4 cycles;
  - BEQ and NOP: 3 cycles;
  - LW: 5 cycles;
  - SW: 4 cycles.

## Structure
- Shared package `core_pkg`:
  - `alu_op_e` enum (AND=0 … SLL=10), reused by the ALU;
  - `opcode_e` (adds LI=12, NOP=13, HALT=14/15);
  - `ctrl_state_e`;
  - instruction field slice constants.
- One sub-module `instr_decode`: combinational opcode → {alu_op, writes_rf, is_mem, is_store, is_branch, is_halt, use_imm}. The FSM and PC logic stay in `core_ctrl`.

## Test plan
- LI R1,5; LI R2,3; ADD R1,R2 with zero-wait memories:
  - R1=8 written in the WB cycle;
  - `alu_op`=4 for exactly one cycle;
  - PC=3 after 12 cycles.
- BEQ with R0=R1=7, R3=0x40 → PC=0x40; repeat with R1=6 → PC+1.
- SW R1→[R2] with R1=0xAA, R2=0x10 and `dmem_valid` delayed 3 cycles:
  - `dmem_req`, `dmem_we` and `dmem_addr`=0x10 held for all 4 cycles;
  - `rf_we` never asserted.
- LW then HALT:
  - the loaded value reaches R[rd];
  - `halted`=1 stays with PC frozen;
  - a `start` pulse is ignored.
- `rst_n` low during MEM with `dmem_req`=1:
  - outputs 0 in the same cycle;
  - state IDLE;
  - after release, `start` refetches from address 0.
- PC wrap: a NOP at address 255 leads to the next fetch at address 0.
